alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter: ADDR_W, default 5, register-file destination address width.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  ALU result presented this cycle.
REQ-005 in_ready  output  1  block can accept a result this cycle.
REQ-006 alu_out  input  32  ALU result word.
REQ-007 alu_flag  input  3  ALU flags: [0] carry, [1] in1==0, [2] in1 negative.
REQ-008 rd  input  ADDR_W  destination register index.
REQ-009 rd_we  input  1  result is to be written back.
REQ-010 br_cond  input  3  branch condition code for this op.
REQ-011 wb_valid  output  1  write-back entry available.
REQ-012 wb_ready  input  1  register file accepts the entry.
REQ-013 wb_data  output  32  write-back data.
REQ-014 wb_addr  output  ADDR_W  write-back register index.
REQ-015 br_taken  output  1  one-cycle pulse: accepted op's branch condition true.
REQ-016 wb_count  output  2  entries held (0..2).

Function
REQ-017 Accept occurs when in_valid and in_ready are both 1 on a rising clk edge; drain occurs when wb_valid and wb_ready are both 1.
REQ-018 Storage: 2-entry FIFO of {alu_out, rd}; only accepted ops with rd_we=1 are stored; ops with rd_we=0 are accepted, branch-evaluated, and discarded.
REQ-019 in_ready = 1 when wb_count < 2, or when wb_count == 2 and a drain occurs in the same cycle (combinational from wb_ready).
REQ-020 wb_valid = (wb_count != 0); wb_data and wb_addr = oldest entry; they hold stable while wb_valid=1 and wb_ready=0.
REQ-021 Write-back latency: an entry accepted into an empty FIFO appears on wb_valid the cycle after acceptance; there is no bypass from input to output.
REQ-022 Ordering: entries drain in acceptance order.
REQ-023 Simultaneous accept (rd_we=1) and drain: wb_count unchanged, both pointers advance.
REQ-024 Pointers are 1 bit each and wrap modulo 2; full/empty are derived from wb_count, never from pointer equality alone.
REQ-025 Writes with rd == 0 are stored and drained normally; suppressing writes to register 0 is the register file's responsibility.
REQ-026 Branch evaluation uses alu_flag as sampled at the accepting edge: 000 never, 001 always, 010 flag[1], 011 !flag[1], 100 flag[2], 101 !flag[2] && !flag[1], 110 flag[0], 111 !flag[0].
REQ-027 br_taken is registered: it is 1 for exactly the one cycle following an accepting edge whose condition is true, else 0; back-to-back accepts yield back-to-back pulses.
REQ-028 No accept occurs while in_ready=0; in_valid with in_ready=0 has no effect on state or br_taken.
REQ-029 wb_count changes by at most 1 per cycle.

Reset
REQ-030 While rst=1: wb_count=0, both pointers 0, wb_valid=0, br_taken=0; in_ready=1 once rst deasserts.
REQ-031 Assertion of rst mid-operation discards all held entries and any pending br_taken pulse immediately, without waiting for a clk edge.
REQ-032 wb_data and wb_addr are 0 while rst=1.

Verification
REQ-033 Reset then single accept alu_out=0x0000_00A5, rd=3, rd_we=1, wb_ready=1 -> next cycle wb_valid=1, wb_data=0x0000_00A5, wb_addr=3; following cycle wb_count=0.
REQ-034 wb_ready=0, accept 0x11 (rd=1), 0x22 (rd=2) -> wb_count=2, in_ready=0; third in_valid ignored; raise wb_ready -> 0x11 then 0x22 drain in order.
REQ-035 FIFO full with wb_ready=1 and in_valid=1 (0x33, rd=4) -> in_ready=1, accept and drain same edge, wb_count stays 2, final drain order 0x22, 0x33.
REQ-036 br_cond=010 with alu_flag=3'b010, then br_cond=101 with alu_flag=3'b100, rd_we=0 -> br_taken 1 then 0; wb_count stays 0.
REQ-037 br_cond=110 with alu_flag[0]=1 on consecutive accepts -> br_taken high two consecutive cycles.
REQ-038 Two entries held, br_taken pending, rst pulsed between clk edges -> wb_valid=0, br_taken=0, wb_count=0 immediately.

Source files
------------

// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback
//
// Decouples the ALU from the register-file write port with a 2-entry FIFO of
// {result, destination}. It also evaluates the op's branch condition against
// the ALU flags and reports the outcome as a one-cycle registered pulse.
//
// Ports
//   clk, rst      : clock; asynchronous active-high reset
//   in_valid      : ALU result presented this cycle
//   in_ready      : block can accept a result this cycle
//   alu_out       : 32-bit ALU result
//   alu_flag      : [0] carry, [1] operand zero, [2] operand negative
//   rd, rd_we     : destination index and write-back request
//   br_cond       : branch condition code of the presented op
//   wb_valid      : oldest entry is available on wb_data/wb_addr
//   wb_ready      : register file takes the entry this cycle
//   wb_data       : write-back data (oldest entry)
//   wb_addr       : write-back register index (oldest entry)
//   br_taken      : pulse, accepted op's branch condition was true
//   wb_count      : entries currently held (0..2)
// ---------------------------------------------------------------------------
module alu_writeback #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       alu_out,
    input  logic [2:0]        alu_flag,
    input  logic [ADDR_W-1:0] rd,
    input  logic              rd_we,
    input  logic [2:0]        br_cond,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_data,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              br_taken,
    output logic [1:0]        wb_count
);

    localparam int DATA_W = 32;

    logic [DATA_W-1:0] data_mem [2];
    logic [ADDR_W-1:0] addr_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              accept;
    logic              drain;
    logic              push;

    function automatic logic eval_branch(input logic [2:0] cond,
                                         input logic [2:0] flag);
        logic taken;
        case (cond)
            3'b000:  taken = 1'b0;
            3'b001:  taken = 1'b1;
            3'b010:  taken = flag[1];
            3'b011:  taken = !flag[1];
            3'b100:  taken = flag[2];
            3'b101:  taken = !flag[2] && !flag[1];
            3'b110:  taken = flag[0];
            default: taken = !flag[0];
        endcase
        return taken;
    endfunction

    // When full, wb_valid is necessarily 1, so a drain this cycle is simply
    // wb_ready; that frees a slot for an accept on the same edge.
    assign in_ready = (wb_count != 2'd2) || wb_ready;
    assign wb_valid = (wb_count != 2'd0);
    assign accept   = in_valid && in_ready;
    assign drain    = wb_valid && wb_ready;
    assign push     = accept && rd_we;

    // Output straight from storage: no input-to-output bypass.
    assign wb_data  = data_mem[rd_ptr];
    assign wb_addr  = addr_mem[rd_ptr];

    // ---- stage: accept edge -> FIFO control and branch pulse ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_count <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            br_taken <= accept && eval_branch(br_cond, alu_flag);
            if (push)
                wr_ptr <= ~wr_ptr;
            if (drain)
                rd_ptr <= ~rd_ptr;
            // Occupancy comes only from this counter, never from pointers.
            if (push && !drain)
                wb_count <= wb_count + 2'd1;
            else if (!push && drain)
                wb_count <= wb_count - 2'd1;
        end
    end

    // Storage is cleared on reset so the outputs read zero while held in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_mem[0] <= '0;
            data_mem[1] <= '0;
            addr_mem[0] <= '0;
            addr_mem[1] <= '0;
        end else if (push) begin
            data_mem[wr_ptr] <= alu_out;
            addr_mem[wr_ptr] <= rd;
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       alu_out;
    logic [2:0]        alu_flag;
    logic [ADDR_W-1:0] rd;
    logic              rd_we;
    logic [2:0]        br_cond;
    logic              wb_valid;
    logic              wb_ready;
    logic [31:0]       wb_data;
    logic [ADDR_W-1:0] wb_addr;
    logic              br_taken;
    logic [1:0]        wb_count;

    alu_writeback #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_out  (alu_out),
        .alu_flag (alu_flag),
        .rd       (rd),
        .rd_we    (rd_we),
        .br_cond  (br_cond),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_data  (wb_data),
        .wb_addr  (wb_addr),
        .br_taken (br_taken),
        .wb_count (wb_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [2:0]  fl;
        logic [4:0]  rdi;
        logic        we;
        logic [2:0]  bc;
        logic        wr;
        logic        e_ir;   // in_ready before the edge
        logic        e_v;    // after the edge
        logic [1:0]  e_c;
        logic [31:0] e_d;
        logic [4:0]  e_a;
        logic        e_br;
    } vec_t;

    vec_t tbl[15];

    // Reference model: the FIFO as a queue of {addr, data}, branch rule table.
    logic [36:0] q[$];
    logic        br_exp;

    function automatic logic ref_cond(input logic [2:0] c, input logic [2:0] f);
        logic carry, zero, neg;
        carry = f[0]; zero = f[1]; neg = f[2];
        case (c)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd2: return zero;
            3'd3: return !zero;
            3'd4: return neg;
            3'd5: return !neg && !zero;
            3'd6: return carry;
            default: return !carry;
        endcase
    endfunction

    task automatic idle_inputs();
        in_valid = 0; alu_out = 0; alu_flag = 0; rd = 0; rd_we = 0;
        br_cond = 0; wb_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1;
        #1;
        chk("rst_wb_count", 32'(wb_count), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_br_taken", 32'(br_taken), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_addr", 32'(wb_addr), 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        q.delete();
        br_exp = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        //                 iv d             fl     rd  we bc     wr   ir v  c  data          a  br
        tbl[0]  = '{1, 32'h0000_00A5, 3'b000, 3, 1, 3'b000, 1,   1, 1, 1, 32'h0000_00A5, 3, 0};
        tbl[1]  = '{0, 32'h0,         3'b000, 0, 0, 3'b000, 1,   1, 0, 0, 32'h0,         0, 0};
        tbl[2]  = '{1, 32'h11,        3'b000, 1, 1, 3'b000, 0,   1, 1, 1, 32'h11,        1, 0};
        tbl[3]  = '{1, 32'h22,        3'b000, 2, 1, 3'b000, 0,   1, 1, 2, 32'h11,        1, 0};
        tbl[4]  = '{1, 32'h99,        3'b000, 7, 1, 3'b001, 0,   0, 1, 2, 32'h11,        1, 0};
        tbl[5]  = '{1, 32'h33,        3'b000, 4, 1, 3'b000, 1,   1, 1, 2, 32'h22,        2, 0};
        tbl[6]  = '{0, 32'h0,         3'b000, 0, 0, 3'b000, 1,   1, 1, 1, 32'h33,        4, 0};
        tbl[7]  = '{0, 32'h0,         3'b000, 0, 0, 3'b000, 1,   1, 0, 0, 32'h0,         0, 0};
        tbl[8]  = '{1, 32'h5,         3'b010, 9, 0, 3'b010, 1,   1, 0, 0, 32'h0,         0, 1};
        tbl[9]  = '{1, 32'h6,         3'b100, 9, 0, 3'b101, 1,   1, 0, 0, 32'h0,         0, 0};
        tbl[10] = '{1, 32'h7,         3'b001, 9, 0, 3'b110, 1,   1, 0, 0, 32'h0,         0, 1};
        tbl[11] = '{1, 32'h8,         3'b001, 9, 0, 3'b110, 1,   1, 0, 0, 32'h0,         0, 1};
        tbl[12] = '{0, 32'h0,         3'b001, 0, 0, 3'b110, 1,   1, 0, 0, 32'h0,         0, 0};
        tbl[13] = '{1, 32'hDEAD_BEEF, 3'b000, 0, 1, 3'b001, 0,   1, 1, 1, 32'hDEAD_BEEF, 0, 1};
        tbl[14] = '{0, 32'h0,         3'b000, 0, 0, 3'b000, 1,   1, 0, 0, 32'h0,         0, 0};

        do_reset();

        // Directed table: one row per clock.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            in_valid = tbl[i].iv; alu_out = tbl[i].d; alu_flag = tbl[i].fl;
            rd = tbl[i].rdi; rd_we = tbl[i].we; br_cond = tbl[i].bc; wb_ready = tbl[i].wr;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_wb_valid", i), 32'(wb_valid), 32'(tbl[i].e_v));
            chk($sformatf("tbl%0d_wb_count", i), 32'(wb_count), 32'(tbl[i].e_c));
            chk($sformatf("tbl%0d_br_taken", i), 32'(br_taken), 32'(tbl[i].e_br));
            if (tbl[i].e_v) begin
                chk($sformatf("tbl%0d_wb_data", i), wb_data, tbl[i].e_d);
                chk($sformatf("tbl%0d_wb_addr", i), 32'(wb_addr), 32'(tbl[i].e_a));
            end
        end

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic exp_ir, acc, drn;
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            alu_out  = $urandom;
            alu_flag = 3'($urandom);
            rd       = ADDR_W'($urandom);
            rd_we    = ($urandom_range(0, 4) != 0);
            br_cond  = 3'($urandom);
            wb_ready = ($urandom_range(0, 2) == 0);
            exp_ir = (q.size() < 2) || wb_ready;
            acc    = in_valid && exp_ir;
            drn    = (q.size() != 0) && wb_ready;
            #1;
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_ir));
            @(posedge clk);
            if (drn) void'(q.pop_front());
            if (acc && rd_we) q.push_back({rd, alu_out});
            br_exp = acc && ref_cond(br_cond, alu_flag);
            #1;
            chk("rnd_wb_count", 32'(wb_count), 32'(q.size()));
            chk("rnd_wb_valid", 32'(wb_valid), 32'(q.size() != 0));
            chk("rnd_br_taken", 32'(br_taken), 32'(br_exp));
            if (q.size() != 0) begin
                chk("rnd_wb_data", wb_data, q[0][31:0]);
                chk("rnd_wb_addr", 32'(wb_addr), 32'(q[0][36:32]));
            end
        end

        // Asynchronous reset in the middle of a cycle with a full FIFO and a
        // branch pulse pending.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1; alu_out = 32'h100 + i; rd = ADDR_W'(i + 1); rd_we = 1;
            br_cond = 3'b001; wb_ready = 0;
        end
        @(posedge clk);
        #1;
        chk("arst_pre_count", 32'(wb_count), 2);
        chk("arst_pre_br", 32'(br_taken), 1);
        #2;
        rst = 1;
        #1;
        chk("arst_wb_valid", 32'(wb_valid), 0);
        chk("arst_br_taken", 32'(br_taken), 0);
        chk("arst_wb_count", 32'(wb_count), 0);
        chk("arst_wb_data", wb_data, 0);
        @(negedge clk);
        idle_inputs();
        rst = 0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
